// File: rtl/i2c_sim_pkg.sv
// Shared types and widths for the simulated I2C register target.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, address and byte widths.
package i2c_sim_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int BYTE_W     = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_WAIT
   } state_e;

endpackage

// File: rtl/i2c_sim_bus_mon.sv
// Synchronises SCL/SDA and detects SCL edges plus START/STOP conditions.
// Latency: pin change to event pulse is 3 clk_i cycles (2 sync flops + 1 event register).
// Backpressure: none; observes the bus only.
// Ports: clk_i, rst_ni (sync, active low); scl_i/sda_i raw bus levels;
//        sda_o SDA level aligned with the event pulses; scl_rise_o, scl_fall_o,
//        start_o, stop_o single-cycle event pulses.
module i2c_sim_bus_mon (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_dly_q, sda_dly_q;
   logic       scl_rise_q, scl_fall_q, start_q, stop_q;

   // Sync stages reset to 1 (idle bus) so leaving reset never fakes a START.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_dly_q  <= scl_sync_q[1];
         sda_dly_q  <= sda_sync_q[1];
         scl_rise_q <= scl_sync_q[1] & ~scl_dly_q;
         scl_fall_q <= ~scl_sync_q[1] & scl_dly_q;
         // SDA edges only count as START/STOP while SCL is stable high.
         start_q    <= scl_sync_q[1] & scl_dly_q & ~sda_sync_q[1] & sda_dly_q;
         stop_q     <= scl_sync_q[1] & scl_dly_q & sda_sync_q[1] & ~sda_dly_q;
      end
   end

   assign sda_o      = sda_dly_q;
   assign scl_rise_o = scl_rise_q;
   assign scl_fall_o = scl_fall_q;
   assign start_o    = start_q;
   assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_sim_target.sv
// Virtual 24Cxx-style I2C register target (7-bit address, byte pointer, auto-increment).
// Latency: SDA drive updates 4 clk_i after the SCL pin falls; wr_valid_o 1 cycle after bit-0 rise event.
// Backpressure: optional clock stretch after each ACK when I2C_SIM_TARGET_STRETCH_EN is defined.
// Ports: clk_i, rst_ni (sync, active low); scl_i/sda_i resolved bus levels;
//        scl_pd_o/sda_pd_o open-drain pull-downs; wr_valid_o/wr_idx_o/wr_data_o
//        register-write pulse; busy_o high while addressed.
module i2c_sim_target
   import i2c_sim_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TargetAddr    = 7'h50,
   parameter int                    NumRegs       = 16,
   parameter int                    StretchCycles = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       scl_i,
   input  logic                       sda_i,
   output logic                       scl_pd_o,
   output logic                       sda_pd_o,
   output logic                       wr_valid_o,
   output logic [$clog2(NumRegs)-1:0] wr_idx_o,
   output logic [BYTE_W-1:0]          wr_data_o,
   output logic                       busy_o
);

   localparam int IDX_W = $clog2(NumRegs);

   logic sda_lvl, scl_rise, scl_fall, start, stop, rise_ok;

   i2c_sim_bus_mon u_bus_mon (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_o      (sda_lvl),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop)
   );

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [BYTE_W-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d, ptr_inc;
   logic                sda_pd_q, sda_pd_d;
   logic                busy_q, busy_d;
   logic                wr_en, stretch_go;
   logic                wr_valid_q;
   logic [IDX_W-1:0]    wr_idx_q;
   logic [BYTE_W-1:0]   wr_data_q;
   logic [BYTE_W-1:0]   regs_q [NumRegs];
   logic [BYTE_W-1:0]   rx_byte;

   assign ptr_inc = ptr_q + 1'b1;
   assign rx_byte = {shift_q[BYTE_W-2:0], sda_lvl};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      sda_pd_d   = sda_pd_q;
      busy_d     = busy_q;
      wr_en      = 1'b0;
      stretch_go = 1'b0;
      if (stop) begin
         state_d  = ST_IDLE;
         cnt_d    = 4'd0;
         sda_pd_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start) begin
         state_d = ST_ADDR;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (rise_ok) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     if (state_q == ST_ADDR) begin
                        if (rx_byte[BYTE_W-1:1] == TargetAddr) begin
                           state_d = ST_ADDR_ACK;
                           busy_d  = 1'b1;
                        end else begin
                           state_d = ST_WAIT;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == ST_PTR) begin
                        ptr_d   = rx_byte[IDX_W-1:0];
                        state_d = ST_PTR_ACK;
                     end else begin
                        wr_en   = 1'b1;
                        ptr_d   = ptr_inc;
                        state_d = ST_WDATA_ACK;
                     end
                  end
               end
            end
            // First fall after the 8th bit starts the ACK; the next one ends it.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_pd_q) begin
                     sda_pd_d = 1'b1;
                  end else begin
                     sda_pd_d   = 1'b0;
                     stretch_go = 1'b1;
                     cnt_d      = 4'd0;
                     state_d    = ST_WDATA;
                     if (state_q == ST_ADDR_ACK) begin
                        if (shift_q[0]) begin
                           // Read: MSB goes out on this same fall.
                           state_d  = ST_RDATA;
                           sda_pd_d = ~regs_q[ptr_q][BYTE_W-1];
                           shift_d  = {regs_q[ptr_q][BYTE_W-2:0], 1'b0};
                           cnt_d    = 4'd1;
                        end else begin
                           state_d = ST_PTR;
                        end
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_pd_d = 1'b0;
                     state_d  = ST_RACK;
                  end else begin
                     // cnt 0 here means we just came back from a controller ACK.
                     stretch_go = (cnt_q == 4'd0);
                     sda_pd_d   = ~shift_q[BYTE_W-1];
                     shift_d    = {shift_q[BYTE_W-2:0], 1'b0};
                     cnt_d      = cnt_q + 4'd1;
                  end
               end
            end
            ST_RACK: begin
               if (rise_ok) begin
                  if (!sda_lvl) begin
                     ptr_d   = ptr_inc;
                     shift_d = regs_q[ptr_inc];
                     cnt_d   = 4'd0;
                     state_d = ST_RDATA;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         shift_q    <= '0;
         ptr_q      <= '0;
         sda_pd_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_idx_q   <= '0;
         wr_data_q  <= '0;
         for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         sda_pd_q   <= sda_pd_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_en;
         if (wr_en) begin
            regs_q[ptr_q] <= rx_byte;
            wr_idx_q      <= ptr_q;
            wr_data_q     <= rx_byte;
         end
      end
   end

`ifdef I2C_SIM_TARGET_STRETCH_EN
   logic [7:0] stretch_cnt_q;
   logic       scl_pd_q;

   // Starts in the same cycle sda_pd_o updates, so SDA is set up before release.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || stop) begin
         scl_pd_q      <= 1'b0;
         stretch_cnt_q <= 8'd0;
      end else if (stretch_go) begin
         scl_pd_q      <= 1'b1;
         stretch_cnt_q <= 8'(StretchCycles - 1);
      end else if (scl_pd_q) begin
         if (stretch_cnt_q == 8'd0) scl_pd_q <= 1'b0;
         else stretch_cnt_q <= stretch_cnt_q - 8'd1;
      end
   end

   assign scl_pd_o = scl_pd_q;
   assign rise_ok  = scl_rise & ~scl_pd_q;
`else
   logic unused_stretch;
   assign unused_stretch = stretch_go ^ (StretchCycles == 0);
   assign scl_pd_o       = 1'b0;
   assign rise_ok        = scl_rise;
`endif

   assign sda_pd_o   = sda_pd_q;
   assign busy_o     = busy_q;
   assign wr_valid_o = wr_valid_q;
   assign wr_idx_o   = wr_idx_q;
   assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_i2c_sim_target.sv
// Directed bench for i2c_sim_target: bit-banged I2C controller wire-ANDed with the target.
// Latency: n/a.
// Backpressure: controller waits (bounded) for SCL to actually go high, honouring stretch.
`timescale 1ns/1ps
module tb_i2c_sim_target;

   localparam int H = 10;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       scl_bus, sda_bus;
   logic       scl_pd_o, sda_pd_o, wr_valid_o, busy_o;
   logic [3:0] wr_idx_o;
   logic [7:0] wr_data_o;

   int checks = 0;
   int failures = 0;

   assign scl_bus = scl_m & ~scl_pd_o;
   assign sda_bus = sda_m & ~sda_pd_o;

   always #5 clk = ~clk;

   i2c_sim_target #(
      .TargetAddr    (7'h50),
      .NumRegs       (16),
      .StretchCycles (8)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .scl_i      (scl_bus),
      .sda_i      (sda_bus),
      .scl_pd_o   (scl_pd_o),
      .sda_pd_o   (sda_pd_o),
      .wr_valid_o (wr_valid_o),
      .wr_idx_o   (wr_idx_o),
      .wr_data_o  (wr_data_o),
      .busy_o     (busy_o)
   );

   // Write-pulse and stretch-length logs
   int         wr_n = 0;
   logic [3:0] wr_idx_log [64];
   logic [7:0] wr_dat_log [64];
   int         st_n = 0;
   int         st_run = 0;
   int         st_log [64];
   int         pd_cycles = 0;

   always @(negedge clk) begin
      if (wr_valid_o && wr_n < 64) begin
         wr_idx_log[wr_n] = wr_idx_o;
         wr_dat_log[wr_n] = wr_data_o;
         wr_n++;
      end
      if (scl_pd_o) begin
         st_run++;
         pd_cycles++;
      end else if (st_run != 0) begin
         if (st_n < 64) st_log[st_n] = st_run;
         st_n++;
         st_run = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic wait_scl_high();
      int n = 0;
      while (scl_bus !== 1'b1 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL scl_release: got scl=%b want 1 within 200 cycles", scl_bus);
      end
   endtask

   task automatic i2c_start();
      tick(3); sda_m = 1'b1;
      tick(H); scl_m = 1'b1; wait_scl_high();
      tick(H); sda_m = 1'b0;
      tick(H); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(3); sda_m = 1'b0;
      tick(H); scl_m = 1'b1; wait_scl_high();
      tick(H); sda_m = 1'b1;
      tick(H);
   endtask

   task automatic clk_bit(input logic b);
      tick(3); sda_m = b;
      tick(H - 3); scl_m = 1'b1; wait_scl_high();
      tick(H); scl_m = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) clk_bit(b[i]);
      tick(3); sda_m = 1'b1;
      tick(H - 3); scl_m = 1'b1; wait_scl_high();
      tick(H / 2); ack = sda_bus;
      tick(H / 2); scl_m = 1'b0;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic [7:0] v = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         tick(3); sda_m = 1'b1;
         tick(H - 3); scl_m = 1'b1; wait_scl_high();
         tick(H / 2); v[i] = sda_bus;
         tick(H / 2); scl_m = 1'b0;
      end
      tick(3); sda_m = nack;
      tick(H - 3); scl_m = 1'b1; wait_scl_high();
      tick(H); scl_m = 1'b0;
      b = v;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      tick(5);
      @(negedge clk);
      checks++; if (sda_pd_o !== 1'b0) begin failures++; $display("FAIL rst_sda_pd: got %b want 0", sda_pd_o); end
      checks++; if (scl_pd_o !== 1'b0) begin failures++; $display("FAIL rst_scl_pd: got %b want 0", scl_pd_o); end
      checks++; if (wr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy_o); end
      checks++; if ({wr_idx_o, wr_data_o} !== 12'h000) begin failures++; $display("FAIL rst_wr_bus: got %h want 000", {wr_idx_o, wr_data_o}); end
      rst_ni = 1'b1;
      tick(10);
   endtask

   task automatic test_write();
      logic       ack;
      int         n0 = wr_n;
      logic [7:0] bytes [4] = '{8'hA0, 8'h03, 8'hA5, 8'h5A};
      i2c_start();
      for (int i = 0; i < 4; i++) begin
         write_byte(bytes[i], ack);
         checks++; if (ack !== 1'b0) begin failures++; $display("FAIL write_ack%0d: got %b want 0", i, ack); end
      end
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", busy_o); end
      i2c_stop();
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stop_busy: got %b want 0", busy_o); end
      checks++; if (wr_n - n0 !== 2) begin failures++; $display("FAIL write_count: got %0d want 2", wr_n - n0); end
      checks++; if ({wr_idx_log[n0], wr_dat_log[n0]} !== 12'h3A5) begin failures++; $display("FAIL write_pulse0: got %h want 3a5", {wr_idx_log[n0], wr_dat_log[n0]}); end
      checks++; if ({wr_idx_log[n0+1], wr_dat_log[n0+1]} !== 12'h45A) begin failures++; $display("FAIL write_pulse1: got %h want 45a", {wr_idx_log[n0+1], wr_dat_log[n0+1]}); end
   endtask

   task automatic test_repeated_start_read();
      logic       ack;
      logic [7:0] d0, d1;
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'hA1, ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL sr_addr_ack: got %b want 0", ack); end
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      checks++; if (d0 !== 8'hA5) begin failures++; $display("FAIL sr_read0: got %h want a5", d0); end
      checks++; if (d1 !== 8'h5A) begin failures++; $display("FAIL sr_read1: got %h want 5a", d1); end
      tick(6);
      checks++; if (sda_pd_o !== 1'b0) begin failures++; $display("FAIL nack_release: got %b want 0", sda_pd_o); end
      i2c_stop();
   endtask

   task automatic test_wrong_addr();
      logic ack;
      int   n0 = wr_n;
      i2c_start();
      write_byte(8'hA2, ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wrong_addr_nack: got %b want 1", ack); end
      tick(2);
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL wrong_addr_busy: got %b want 0", busy_o); end
      write_byte(8'h77, ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wrong_addr_data_nack: got %b want 1", ack); end
      i2c_stop();
      checks++; if (wr_n !== n0) begin failures++; $display("FAIL wrong_addr_wr: got %0d pulses want 0", wr_n - n0); end
   endtask

   task automatic test_wrap();
      logic       ack;
      logic [7:0] d0, d1;
      int         n0 = wr_n;
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h0F, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack);
      i2c_stop();
      checks++; if ({wr_idx_log[n0], wr_dat_log[n0]} !== 12'hF11) begin failures++; $display("FAIL wrap_pulse0: got %h want f11", {wr_idx_log[n0], wr_dat_log[n0]}); end
      checks++; if ({wr_idx_log[n0+1], wr_dat_log[n0+1]} !== 12'h022) begin failures++; $display("FAIL wrap_pulse1: got %h want 022", {wr_idx_log[n0+1], wr_dat_log[n0+1]}); end
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h0F, ack);
      i2c_start();
      write_byte(8'hA1, ack);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      i2c_stop();
      checks++; if (d0 !== 8'h11) begin failures++; $display("FAIL wrap_read0: got %h want 11", d0); end
      checks++; if (d1 !== 8'h22) begin failures++; $display("FAIL wrap_read1: got %h want 22", d1); end
   endtask

   task automatic test_reset_mid_read();
      logic       ack;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'hA1, ack);
      // 0xA5: bits 7..4 = 1,0,1,0, then bit 3 = 0 is driven low
      for (int i = 0; i < 4; i++) clk_bit(1'b1);
      tick(6);
      checks++; if (sda_pd_o !== 1'b1) begin failures++; $display("FAIL rdata_bit3_drive: got %b want 1", sda_pd_o); end
      @(negedge clk);
      rst_ni = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (sda_pd_o !== 1'b0) begin failures++; $display("FAIL reset_release: got %b want 0", sda_pd_o); end
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(5);
      rst_ni = 1'b1;
      tick(10);
      // ptr is 0 after reset; reg 0 held 0x22 before reset
      i2c_start();
      write_byte(8'hA1, ack);
      read_byte(1'b1, d);
      i2c_stop();
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg0: got %h want 00", d); end
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'hA1, ack);
      read_byte(1'b1, d);
      i2c_stop();
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg3: got %h want 00", d); end
   endtask

   task automatic test_stretch();
      logic ack;
      int   n0 = wr_n;
      int   s0 = st_n;
      int   p0 = pd_cycles;
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h07, ack);
      write_byte(8'h3C, ack);
      i2c_stop();
      tick(4);
      checks++; if ({wr_idx_log[n0], wr_dat_log[n0]} !== 12'h73C) begin failures++; $display("FAIL stretch_data: got %h want 73c", {wr_idx_log[n0], wr_dat_log[n0]}); end
`ifdef I2C_SIM_TARGET_STRETCH_EN
      checks++; if (st_n - s0 !== 3) begin failures++; $display("FAIL stretch_count: got %0d want 3", st_n - s0); end
      for (int i = s0; i < st_n && i < 64; i++) begin
         checks++; if (st_log[i] !== 8) begin failures++; $display("FAIL stretch_len%0d: got %0d want 8", i - s0, st_log[i]); end
      end
`else
      checks++; if (pd_cycles - p0 !== 0) begin failures++; $display("FAIL no_stretch: got %0d pd cycles want 0", pd_cycles - p0); end
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_repeated_start_read();
      test_wrong_addr();
      test_wrap();
      test_reset_mid_read();
      test_stretch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_sim_target.md
# i2c_sim_target

Parametrised virtual I2C target for the Verilator top level, attached to either I2C bus in place of the currently undriven pull-up. It models a 24Cxx-style register device: a 7-bit address, a byte pointer and a register file with auto-increment. It gives software tests a real device to address, write and read back. The block is clocked by the system clock and oversamples SCL/SDA. It drives the bus only through open-drain pull-down outputs, which the top level wire-ANDs with the controller's drive.

## Interface
Parameters:
- TargetAddr, 7'h50: 7-bit device address matched in the address byte.
- NumRegs, 16: register file depth; power of two, 2..256.
- StretchCycles, 8: clock-stretch length in clk_i cycles; used only with the stretch macro; 1..255.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  synchronous, active-low reset.
- scl_i  in  1  resolved SCL bus level.
- sda_i  in  1  resolved SDA bus level.
- scl_pd_o  out  1  1 = pull SCL low (stretch).
- sda_pd_o  out  1  1 = pull SDA low (ACK or data 0).
- wr_valid_o  out  1  one-cycle pulse per register written.
- wr_idx_o  out  $clog2(NumRegs)  index of the written register.
- wr_data_o  out  8  value written.
- busy_o  out  1  high from a matched address until STOP or a non-matching START.

## Operation
- Front end: 2-flop synchronisers on scl_i and sda_i, plus one delay register each. The block derives scl_rise, scl_fall, start and stop from these.
  - start: SDA high to low while SCL is high.
  - stop: SDA low to high while SCL is high.
- Bits are sampled on scl_rise. sda_pd_o changes only on scl_fall, and during reset.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT.
- start in any state: go to ADDR and clear the bit counter. This covers repeated START.
- stop in any state: go to IDLE and release both pull-downs.
- ADDR: shift 8 bits, MSB first. Bits 7:1 == TargetAddr goes to ADDR_ACK. A mismatch goes to WAIT with SDA released, so the controller sees a NACK.
- ADDR_ACK: drive SDA low for the 9th clock. On its scl_fall:
  - R/W=0 goes to PTR.
  - R/W=1 goes to RDATA and loads the shift register from regs[ptr].
- PTR: 8 bits load ptr. ptr keeps its low $clog2(NumRegs) bits; upper bits are ignored. PTR_ACK then goes to WDATA.
- WDATA: 8 bits, then WDATA_ACK.
  - At the 8th scl_rise: write regs[ptr], pulse wr_valid_o, ptr = ptr+1 with wrap to 0.
  - ACK is driven for the 9th clock.
- RDATA: drive the shift register MSB first, each bit on scl_fall. A 0 bit asserts sda_pd_o. After the 8th bit, release SDA and go to RACK.
- RACK: sample on the 9th scl_rise.
  - Controller ACK (SDA=0): ptr = ptr+1 with wrap, load the next byte, return to RDATA.
  - NACK: go to WAIT.
- WAIT: outputs released; leave only on start or stop.
- ptr persists across transactions, so a read without a pointer write continues from the last ptr. Reset sets ptr = 0.
- Simultaneous start and scl edge in one cycle: start wins.

## Timing
- Reset: all outputs 0, state IDLE, ptr 0, all regs 8'h00.
- Reset mid-transfer releases the bus in the cycle after the reset edge.
- Pin-to-event latency: 3 clk_i cycles, made up of two synchroniser stages and one edge register.
- sda_pd_o updates 1 cycle after the internal scl_fall event, i.e. 4 clk_i cycles after the SCL pin falls.
- wr_valid_o is asserted 1 cycle after the internal scl_rise of data bit 0. wr_idx_o and wr_data_o are valid in the same cycle only.
- Minimum SCL low or high period supported: 6 clk_i cycles.

## Configuration
- I2C_SIM_TARGET_STRETCH_EN defined:
  - On the scl_fall that ends each ACK or RACK bit, assert scl_pd_o for StretchCycles cycles, counted from the cycle sda_pd_o updates.
  - SDA for the next bit is set up before the stretch is released.
  - scl_rise events while scl_pd_o is asserted are ignored.
- Undefined: scl_pd_o tied 0, no stretch counter, and StretchCycles is unused.

## Structure
- Package i2c_sim_pkg: FSM state enum, I2C_ADDR_W = 7, BYTE_W = 8.
- Sub-module i2c_sim_bus_mon: synchronisers plus scl_rise, scl_fall, start and stop detection.
- The register file is a flop array inside i2c_sim_target.
- The top level instantiates the target with scl = ~(scl_oe & ~scl_o) & ~scl_pd_o, and likewise for SDA.

## Test plan
- Write 0x50/W, ptr 0x03, data 0xA5, 0x5A -> ACK on all 4 bytes; wr pulses (3,0xA5) then (4,0x5A).
- Repeated START: 0x50/W ptr 0x03, Sr, 0x50/R, read 2 bytes with ACK then NACK -> 0xA5, 0x5A; bus released after the NACK.
- Wrong address 0x51 -> SDA stays high on the 9th clock; busy_o=0; no wr pulse.
- Wrap: ptr 0x0F, write 0x11, 0x22 with NumRegs=16 -> wr_idx 15 then 0; reads back the same.
- Reset asserted during RDATA bit 3 -> sda_pd_o=0 next cycle; regs read 0x00 after reset.
- With I2C_SIM_TARGET_STRETCH_EN and StretchCycles=8 -> scl_pd_o high for exactly 8 cycles after each ACK; transfer data is unchanged.
